// File: rtl/core_pkg.sv
`default_nettype none
// core_pkg: size encodings and store FSM states shared by the execute-stage
// load and store paths so both sides decode identically.
package core_pkg;

  localparam logic [1:0] L_SIZE_BYTE = 2'b00;
  localparam logic [1:0] L_SIZE_HALF = 2'b01;
  localparam logic [1:0] L_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } store_state_e;

  // Shift-enable mode numbers byte lanes in the opposite order.
  function automatic logic [3:0] lane_rev4(input logic [3:0] m);
    return {m[0], m[1], m[2], m[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_store_fairing.sv
`default_nettype none
// execute_store_fairing: combinational byte-lane mask / data placement for a
// store; exact inverse of the load-side alignment.
module execute_store_fairing (
  input  logic        iSHIFT_ENABLE,
  input  logic [1:0]  iSIZE,
  input  logic [1:0]  iADDR,
  input  logic [31:0] iDATA,
  output logic [3:0]  oMASK,
  output logic [31:0] oDATA,
  output logic        oMISALIGN
);
  import core_pkg::*;

  logic [3:0] mask_w;

  always_comb begin
    mask_w    = 4'b0000;
    oDATA     = 32'h0;
    oMISALIGN = 1'b0;
    case (iSIZE)
      L_SIZE_BYTE: begin
        // Offset 0 is the most significant lane.
        mask_w = 4'b1000 >> iADDR;
        oDATA  = {iDATA[7:0], 24'h0} >> {iADDR, 3'b000};
      end
      L_SIZE_HALF: begin
        if (iADDR[0]) begin
          oMISALIGN = 1'b1;
        end else if (iADDR[1]) begin
          mask_w = 4'b0011;
          oDATA  = {16'h0, iDATA[15:0]};
        end else begin
          mask_w = 4'b1100;
          oDATA  = {iDATA[15:0], 16'h0};
        end
      end
      L_SIZE_WORD: begin
        if (iADDR != 2'b00) begin
          oMISALIGN = 1'b1;
        end else begin
          mask_w = 4'b1111;
          oDATA  = iDATA;
        end
      end
      default: oMISALIGN = 1'b1;
    endcase
    oMASK = iSHIFT_ENABLE ? lane_rev4(mask_w) : mask_w;
  end

endmodule
`default_nettype wire

// File: rtl/execute_store_data.sv
`default_nettype none
// execute_store_data: registers a store request, issues one data-memory write
// with handshake, and reports completion or alignment fault.
module execute_store_data #(
  parameter int P_ADDR_N = 32
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iFLUSH,
  input  logic                iSHIFT_ENABLE,
  input  logic                iVALID,
  output logic                oBUSY,
  input  logic [1:0]          iSIZE,
  input  logic [P_ADDR_N-1:0] iADDR,
  input  logic [31:0]         iDATA,
  output logic                oREQ,
  input  logic                iMEM_BUSY,
  output logic [P_ADDR_N-1:0] oMEM_ADDR,
  output logic [3:0]          oMEM_MASK,
  output logic [31:0]         oMEM_DATA,
  input  logic                iMEM_ACK,
  output logic                oDONE,
  output logic                oFAULT
);
  import core_pkg::*;

  store_state_e        state_q;
  logic                req_q;
  logic                done_q;
  logic                fault_q;
  logic                suppress_q;
  logic [P_ADDR_N-1:0] addr_q;
  logic [3:0]          mask_q;
  logic [31:0]         data_q;

  logic [3:0]          fair_mask;
  logic [31:0]         fair_data;
  logic                fair_misalign;

  execute_store_fairing u_fairing (
    .iSHIFT_ENABLE (iSHIFT_ENABLE),
    .iSIZE         (iSIZE),
    .iADDR         (iADDR[1:0]),
    .iDATA         (iDATA),
    .oMASK         (fair_mask),
    .oDATA         (fair_data),
    .oMISALIGN     (fair_misalign)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      suppress_q <= 1'b0;
      addr_q     <= '0;
      mask_q     <= 4'b0000;
      data_q     <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iVALID && !iFLUSH) begin
            if (fair_misalign) begin
              fault_q <= 1'b1;
            end else begin
              state_q    <= ST_REQ;
              req_q      <= 1'b1;
              suppress_q <= 1'b0;
              addr_q     <= {iADDR[P_ADDR_N-1:2], 2'b00};
              mask_q     <= fair_mask;
              data_q     <= fair_data;
            end
          end
        end
        ST_REQ: begin
          // Acceptance commits the write even under flush; only done is lost.
          if (!iMEM_BUSY) begin
            req_q      <= 1'b0;
            state_q    <= ST_WAIT_ACK;
            suppress_q <= iFLUSH;
          end else if (iFLUSH) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_ACK: begin
          if (iMEM_ACK) begin
            done_q     <= !(suppress_q || iFLUSH);
            suppress_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (iFLUSH) begin
            suppress_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign oBUSY     = (state_q != ST_IDLE);
  assign oREQ      = req_q;
  assign oDONE     = done_q;
  assign oFAULT    = fault_q;
  assign oMEM_ADDR = addr_q;
  assign oMEM_MASK = mask_q;
  assign oMEM_DATA = data_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_store_data.sv
`default_nettype none
// tb_execute_store_data: directed table vectors plus handshake/flush/reset sequences.
module tb_execute_store_data;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iFLUSH = 1'b0;
  logic        iSHIFT_ENABLE = 1'b0;
  logic        iVALID = 1'b0;
  logic        oBUSY;
  logic [1:0]  iSIZE = 2'b00;
  logic [31:0] iADDR = 32'h0;
  logic [31:0] iDATA = 32'h0;
  logic        oREQ;
  logic        iMEM_BUSY = 1'b0;
  logic [31:0] oMEM_ADDR;
  logic [3:0]  oMEM_MASK;
  logic [31:0] oMEM_DATA;
  logic        iMEM_ACK = 1'b0;
  logic        oDONE;
  logic        oFAULT;

  int checks = 0;
  int failures = 0;

  execute_store_data #(.P_ADDR_N(32)) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iFLUSH        (iFLUSH),
    .iSHIFT_ENABLE (iSHIFT_ENABLE),
    .iVALID        (iVALID),
    .oBUSY         (oBUSY),
    .iSIZE         (iSIZE),
    .iADDR         (iADDR),
    .iDATA         (iDATA),
    .oREQ          (oREQ),
    .iMEM_BUSY     (iMEM_BUSY),
    .oMEM_ADDR     (oMEM_ADDR),
    .oMEM_MASK     (oMEM_MASK),
    .oMEM_DATA     (oMEM_DATA),
    .iMEM_ACK      (iMEM_ACK),
    .oDONE         (oDONE),
    .oFAULT        (oFAULT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic        sh;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic sh, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    iSHIFT_ENABLE = sh;
    iSIZE         = sz;
    iADDR         = a;
    iDATA         = d;
    iVALID        = 1'b1;
    tick();
    iVALID        = 1'b0;
  endtask

  // Load-side model: pick the halfword selected by the mask, right-justified.
  function automatic logic [31:0] load_half(input logic [3:0] m, input logic sh,
                                            input logic [31:0] d);
    logic [3:0] mm;
    mm = sh ? {m[0], m[1], m[2], m[3]} : m;
    return (mm == 4'b1100) ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 32'h0000_1003, 32'h0000_00A5, 1'b0, 4'b0001, 32'h0000_00A5};
    vecs[1]  = '{1'b0, 2'b00, 32'h0000_1000, 32'hFFFF_FF5A, 1'b0, 4'b1000, 32'h5A00_0000};
    vecs[2]  = '{1'b1, 2'b00, 32'h0000_1001, 32'h0000_0077, 1'b0, 4'b0010, 32'h0077_0000};
    vecs[3]  = '{1'b1, 2'b01, 32'h0000_2000, 32'h0000_1234, 1'b0, 4'b0011, 32'h1234_0000};
    vecs[4]  = '{1'b0, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 4'b0011, 32'h0000_BEEF};
    vecs[5]  = '{1'b1, 2'b01, 32'h0000_2002, 32'h0000_CAFE, 1'b0, 4'b1100, 32'h0000_CAFE};
    vecs[6]  = '{1'b0, 2'b01, 32'h0000_2000, 32'hABCD_1234, 1'b0, 4'b1100, 32'h1234_0000};
    vecs[7]  = '{1'b0, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 2'b10, 32'h0000_3002, 32'h1111_1111, 1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 2'b11, 32'h0000_3000, 32'h2222_2222, 1'b1, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 2'b01, 32'h0000_2001, 32'h3333_3333, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 2'b10, 32'hF000_3004, 32'h0102_0304, 1'b0, 4'b1111, 32'h0102_0304};
    vecs[12] = '{1'b0, 2'b00, 32'h0000_1002, 32'h0000_0011, 1'b0, 4'b0010, 32'h0000_1100};

    // Reset state
    tick();
    check("rst req",  32'(oREQ), 32'd0);
    check("rst busy", 32'(oBUSY), 32'd0);
    check("rst done", 32'(oDONE), 32'd0);
    check("rst fault", 32'(oFAULT), 32'd0);
    check("rst addr", oMEM_ADDR, 32'h0);
    check("rst mask", 32'(oMEM_MASK), 32'h0);
    check("rst data", oMEM_DATA, 32'h0);
    inRESET = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].sh, vecs[i].size, vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d fault", i), 32'(oFAULT), 32'(vecs[i].fault));
      check($sformatf("v%0d req", i), 32'(oREQ), 32'(!vecs[i].fault));
      if (!vecs[i].fault) begin
        check($sformatf("v%0d addr", i), oMEM_ADDR, vecs[i].addr & 32'hFFFF_FFFC);
        check($sformatf("v%0d mask", i), 32'(oMEM_MASK), 32'(vecs[i].mask));
        check($sformatf("v%0d data", i), oMEM_DATA, vecs[i].wdata);
        if (i == 3)
          check("loopback half", load_half(oMEM_MASK, 1'b1, oMEM_DATA), 32'h0000_1234);
        tick();
        check($sformatf("v%0d req after accept", i), 32'(oREQ), 32'd0);
        check($sformatf("v%0d busy wait", i), 32'(oBUSY), 32'd1);
        tick();
        check($sformatf("v%0d no early done", i), 32'(oDONE), 32'd0);
        iMEM_ACK = 1'b1;
        tick();
        iMEM_ACK = 1'b0;
        check($sformatf("v%0d done", i), 32'(oDONE), 32'd1);
        check($sformatf("v%0d busy idle", i), 32'(oBUSY), 32'd0);
      end else begin
        check($sformatf("v%0d busy", i), 32'(oBUSY), 32'd0);
      end
      tick();
      check($sformatf("v%0d done pulse", i), 32'(oDONE), 32'd0);
      check($sformatf("v%0d fault pulse", i), 32'(oFAULT), 32'd0);
    end

    // Memory busy for 4 cycles: request held stable
    iMEM_BUSY = 1'b1;
    issue(1'b0, 2'b10, 32'h0000_4000, 32'h55AA_55AA);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("hold%0d req", c), 32'(oREQ), 32'd1);
      check($sformatf("hold%0d addr", c), oMEM_ADDR, 32'h0000_4000);
      check($sformatf("hold%0d mask", c), 32'(oMEM_MASK), 32'hF);
      check($sformatf("hold%0d data", c), oMEM_DATA, 32'h55AA_55AA);
      tick();
    end
    check("hold req5", 32'(oREQ), 32'd1);
    iMEM_BUSY = 1'b0;
    tick();
    check("hold accepted", 32'(oREQ), 32'd0);
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("hold done", 32'(oDONE), 32'd1);

    // Flush while memory busy: request dropped, stray ack ignored
    iMEM_BUSY = 1'b1;
    issue(1'b0, 2'b01, 32'h0000_6002, 32'h0000_AAAA);
    check("fb req", 32'(oREQ), 32'd1);
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    check("fb req dropped", 32'(oREQ), 32'd0);
    check("fb busy", 32'(oBUSY), 32'd0);
    iMEM_BUSY = 1'b0;
    tick();
    check("fb no reissue", 32'(oREQ), 32'd0);
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("fb stray ack", 32'(oDONE), 32'd0);

    // Flush coinciding with acceptance: write commits, done suppressed
    issue(1'b0, 2'b10, 32'h0000_7000, 32'h7777_7777);
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    check("fa req", 32'(oREQ), 32'd0);
    check("fa busy", 32'(oBUSY), 32'd1);
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("fa done", 32'(oDONE), 32'd0);
    check("fa idle", 32'(oBUSY), 32'd0);

    // Flush in WAIT_ACK: ack still consumed, no done
    issue(1'b0, 2'b10, 32'h0000_8000, 32'h8888_8888);
    tick();
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    check("fw busy", 32'(oBUSY), 32'd1);
    tick();
    check("fw still waiting", 32'(oBUSY), 32'd1);
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("fw done", 32'(oDONE), 32'd0);
    check("fw idle", 32'(oBUSY), 32'd0);
    issue(1'b1, 2'b00, 32'h0000_8003, 32'h0000_00C3);
    check("fw next mask", 32'(oMEM_MASK), 32'h8);
    check("fw next data", oMEM_DATA, 32'h0000_00C3);
    tick();
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("fw next done", 32'(oDONE), 32'd1);

    // Back-to-back: new request presented in the oDONE cycle
    tick();
    issue(1'b0, 2'b10, 32'h0000_5000, 32'h1111_2222);
    tick();
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("b2b done", 32'(oDONE), 32'd1);
    check("b2b busy", 32'(oBUSY), 32'd0);
    issue(1'b0, 2'b00, 32'h0000_5001, 32'h0000_0033);
    check("b2b req", 32'(oREQ), 32'd1);
    check("b2b mask", 32'(oMEM_MASK), 32'h4);
    check("b2b data", oMEM_DATA, 32'h0033_0000);
    tick();
    iMEM_ACK = 1'b1;
    tick();
    iMEM_ACK = 1'b0;
    check("b2b done2", 32'(oDONE), 32'd1);

    // Asynchronous reset in REQ, then stale ack
    iMEM_BUSY = 1'b1;
    issue(1'b0, 2'b10, 32'h0000_9000, 32'h9999_9999);
    check("ar req", 32'(oREQ), 32'd1);
    #2 inRESET = 1'b0;
    #1;
    check("ar req clr", 32'(oREQ), 32'd0);
    check("ar busy clr", 32'(oBUSY), 32'd0);
    check("ar addr clr", oMEM_ADDR, 32'h0);
    check("ar mask clr", 32'(oMEM_MASK), 32'h0);
    check("ar data clr", oMEM_DATA, 32'h0);
    #2 inRESET = 1'b1;
    iMEM_BUSY = 1'b0;
    iMEM_ACK  = 1'b1;
    tick();
    iMEM_ACK  = 1'b0;
    check("ar stale ack", 32'(oDONE), 32'd0);
    check("ar stays idle", 32'(oBUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_store_data.md
Name: execute_store_data

Overview:
Store-side counterpart of the execute-stage load-data alignment logic. It takes a store request from the execute stage (address, size, register data), forms the byte-lane mask and lane-placed write data, and issues one write to the data-memory port. It holds the request until the port accepts it, then waits for write completion before signalling done. Lane and mask conventions are the exact inverse of the load path, so a store followed by a load of the same size and address returns the stored value.

Parameters:
P_ADDR_N, 32, address width in bits (data is fixed at 32 bits)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iFLUSH  in  1  pipeline flush; abort any request not yet accepted
iSHIFT_ENABLE  in  1  lane-order mode; 1 = byte-lane mask bit-reversed (same meaning as on the load path)
iVALID  in  1  store request valid
oBUSY  out  1  block cannot accept iVALID this cycle
iSIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved
iADDR  in  P_ADDR_N  byte address
iDATA  in  32  register data, right-justified for byte and halfword
oREQ  out  1  memory write request
iMEM_BUSY  in  1  memory cannot accept; request is accepted when oREQ && !iMEM_BUSY
oMEM_ADDR  out  P_ADDR_N  word address {iADDR[P_ADDR_N-1:2], 2'b00}
oMEM_MASK  out  4  byte-lane enables
oMEM_DATA  out  32  lane-placed write data
iMEM_ACK  in  1  write completion, 1-cycle pulse
oDONE  out  1  1-cycle pulse: store completed
oFAULT  out  1  1-cycle pulse: misaligned or reserved-size store

Behaviour:
- Reset (inRESET=0, async): state IDLE; oREQ, oDONE, oFAULT = 0; oMEM_ADDR, oMEM_MASK, oMEM_DATA = 0; oBUSY = 0.
- States: IDLE, REQ, WAIT_ACK.
- oBUSY = (state != IDLE).
- IDLE with iVALID and !iFLUSH: decode and register the request.
  - Aligned request: go to REQ; oREQ=1 in the next cycle. Latency is 1 cycle from iVALID to oREQ.
  - Misaligned request (halfword with iADDR[0]=1, word with iADDR[1:0]!=0) or iSIZE=11: oFAULT=1 in the next cycle, state stays IDLE, no oREQ.
- Lane placement, offset k=iADDR[1:0]:
  - Byte: data lane bits [31-8k -: 8] = iDATA[7:0], other lanes 0. Mask = 4'b1000>>k when iSHIFT_ENABLE=0, 4'b0001<<k when iSHIFT_ENABLE=1.
  - Halfword: k=0 puts iDATA[15:0] in [31:16], mask 1100 (0011 when iSHIFT_ENABLE=1). k=2 puts it in [15:0], mask 0011 (1100 when iSHIFT_ENABLE=1).
  - Word: data as-is, mask 1111 in both modes.
- REQ: oREQ and oMEM_* are held stable until acceptance.
  - Accepted (!iMEM_BUSY): next state WAIT_ACK, oREQ=0.
  - iFLUSH in REQ (including the acceptance cycle): the flush wins only if iMEM_BUSY=1. The request is dropped, state goes to IDLE, no oDONE. If accepted in the same cycle, the write is committed: go to WAIT_ACK with done suppressed.
- WAIT_ACK: waits for iMEM_ACK, then oDONE=1 for one cycle and state goes to IDLE.
  - iFLUSH in WAIT_ACK sets a suppress flag. The block still waits for the ack but emits no oDONE.
  - An iMEM_ACK arriving in any other state is ignored.
- iMEM_ACK in the same cycle as acceptance is not possible (memory ack is at least 1 cycle after acceptance). The bench must not drive it.
- The new request may be presented in the cycle oDONE fires (oBUSY is already 0 then). Back-to-back throughput is one store per 3 cycles minimum.
- Reset mid-operation: all state cleared immediately; any outstanding ack after reset is ignored.

Decomposition:
- Shared package (core_pkg) holds:
  - Size encodings: L_SIZE_BYTE=2'b00, L_SIZE_HALF=2'b01, L_SIZE_WORD=2'b10.
  - Store state enum.
  - The same constants are reused by the load-path decode so both sides agree.
- Sub-module execute_store_fairing (combinational): iSHIFT_ENABLE, iSIZE, iADDR[1:0], iDATA -> mask, data, misalign. It mirrors the load-side function and is unit-testable alone.
- The FSM and registers live in the top.

Test Plan:
- Byte store, iSHIFT_ENABLE=0, iADDR=0x1003, iDATA=0x000000A5 -> next cycle oREQ=1, oMEM_ADDR=0x1000, mask 0001, data 0x000000A5. iMEM_ACK 2 cycles later -> oDONE one cycle.
- Halfword, iSHIFT_ENABLE=1, iADDR=0x2000, iDATA=0x1234 -> mask 0011, data 0x12340000. Loopback through the load path with mask 0011, shift enable 1 returns 0x00001234.
- Word at 0x3002 -> oFAULT pulse, oREQ stays 0, oBUSY 0. iSIZE=11 at 0x3000 -> oFAULT pulse.
- iMEM_BUSY held 4 cycles -> oREQ and oMEM_* stable for all 4 cycles, then accepted. iFLUSH during busy -> oREQ drops, no oDONE, no write.
- iFLUSH in WAIT_ACK -> iMEM_ACK still consumed, oDONE=0. A next store issued afterwards completes normally.
- inRESET asserted in REQ -> all outputs 0 asynchronously. A stale iMEM_ACK after release causes no oDONE.
